op_sequencer: RTL and testbench
===============================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of State.
REQ-002 SHALL have parameter CNT_W, default 8, width of Run_count.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Start  input  1  request a new run; sampled only in IDLE.
REQ-006 SHALL have port Data_valid  input  1  operand present on datapath input during a load state.
REQ-007 SHALL have port Out_ack  input  1  consumer has taken the result in OUT state.
REQ-008 SHALL have port Abort  input  1  cancel current run.
REQ-009 SHALL have port State  output  STATE_W  registered step code driving the control decoder (0..12).
REQ-010 SHALL have port Data_ready  output  1  high exactly while State is 1..4.
REQ-011 SHALL have port Busy  output  1  high exactly while State != 0.
REQ-012 SHALL have port Done  output  1  registered one-cycle completion pulse.
REQ-013 SHALL have port Run_count  output  CNT_W  number of completed runs, saturating.

Function
REQ-014 SHALL encode states: 0 IDLE, 1..4 LOAD0..LOAD3, 5..11 CALC steps, 12 OUT; codes 13..15 unreachable.
REQ-015 IDLE: Start=1 -> State 1 next cycle; else hold 0.
REQ-016 LOAD k (State 1..4): Data_valid=1 -> State+1 next cycle; Data_valid=0 -> hold (stall any number of cycles).
REQ-017 CALC (State 5..11): advance by 1 every cycle unconditionally; 7 cycles total; inputs other than Abort ignored.
REQ-018 OUT (State 12): hold until Out_ack=1, then State 0 next cycle.
REQ-019 Done SHALL be high for exactly the one cycle in which State first reads 0 after leaving 12 via Out_ack; low otherwise.
REQ-020 Run_count SHALL increment by 1 on the same edge Done rises; saturate at 2^CNT_W-1, no wrap.
REQ-021 Abort=1 in any state != 0 -> State 0 next cycle; no Done, no Run_count change.
REQ-022 Priority: Abort over Out_ack and Data_valid; Abort in IDLE with Start=1 -> stay IDLE.
REQ-023 Start while Busy SHALL be ignored (not queued).
REQ-024 Minimum run latency Start->Done = 14 cycles (4 load, 7 calc, 1 OUT, 1 return, 1 Done) with Data_valid and Out_ack held high.
REQ-025 Back-to-back: Start=1 in the Done cycle (State 0) SHALL start the next run, State 1 next cycle.
REQ-026 Data_ready, Busy SHALL be Moore outputs decoded from State only, glitch-free relative to Clk.
REQ-027 Unreachable State codes 13..15 SHALL return to 0 next cycle, no Done.

Reset
REQ-028 Rst=1 SHALL immediately force State=0, Done=0, Run_count=0, hence Data_ready=0, Busy=0.
REQ-029 Rst asserted mid-run SHALL discard the run; after release block waits in IDLE for Start.

Structure
REQ-030 Shared package op_seq_pkg SHALL hold state constants ST_IDLE=0, ST_LOAD0=1, ST_LOAD3=4, ST_CALC_FIRST=5, ST_CALC_LAST=11, ST_OUT=12 and STATE_W.
REQ-031 Saturating counter SHALL be sub-module sat_counter (width parameter, inc, count); FSM stays inline.

Verification
REQ-032 Reset, Start=1, Data_valid=1, Out_ack=1 held -> State 0,1,2,...,12,0; Done high 1 cycle at cycle 14; Run_count=1.
REQ-033 Data_valid low 3 cycles in State 2 -> State holds 2 for 3 cycles, Done delayed by 3 cycles.
REQ-034 Abort=1 at State 8 -> State 0 next cycle, Done stays 0, Run_count unchanged.
REQ-035 Out_ack withheld 5 cycles -> State holds 12, Busy=1; Done once after ack.
REQ-036 CNT_W=2, 4 complete runs -> Run_count 1,2,3,3.
REQ-037 Rst pulsed asynchronously (between edges) at State 6 -> State=0, Run_count=0 immediately; Start=1 in the Done cycle of a later run -> State 1 next cycle.

Source files
------------

// File: rtl/op_seq_pkg.sv
// Shared step codes and phase classification for the operand sequencer.
package op_seq_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
    localparam logic [STATE_W-1:0] ST_LOAD0      = 4'd1;
    localparam logic [STATE_W-1:0] ST_LOAD3      = 4'd4;
    localparam logic [STATE_W-1:0] ST_CALC_FIRST = 4'd5;
    localparam logic [STATE_W-1:0] ST_CALC_LAST  = 4'd11;
    localparam logic [STATE_W-1:0] ST_OUT        = 4'd12;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_LOAD,
        PH_CALC,
        PH_OUT,
        PH_BAD
    } phase_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/op_sequencer.sv
// Run sequencer: four operand loads, seven fixed calc steps, then a handshaked output step.
//   state  | meaning
//   0      | IDLE, waiting for Start
//   1..4   | LOAD0..LOAD3, advance on Data_valid
//   5..11  | CALC steps, advance every cycle
//   12     | OUT, wait for Out_ack
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int STATE_W = op_seq_pkg::STATE_W,
    parameter int CNT_W   = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Data_valid,
    input  logic               Out_ack,
    input  logic               Abort,
    output logic [STATE_W-1:0] State,
    output logic               Data_ready,
    output logic               Busy,
    output logic               Done,
    output logic [CNT_W-1:0]   Run_count
);

    localparam logic [STATE_W-1:0] S_IDLE       = STATE_W'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_LOAD0      = STATE_W'(ST_LOAD0);
    localparam logic [STATE_W-1:0] S_LOAD3      = STATE_W'(ST_LOAD3);
    localparam logic [STATE_W-1:0] S_CALC_FIRST = STATE_W'(ST_CALC_FIRST);
    localparam logic [STATE_W-1:0] S_CALC_LAST  = STATE_W'(ST_CALC_LAST);
    localparam logic [STATE_W-1:0] S_OUT        = STATE_W'(ST_OUT);

    logic [STATE_W-1:0] r_state;
    logic               r_done;
    logic               r_busy;
    logic               r_data_ready;
    logic [STATE_W-1:0] w_next;
    logic               w_finish;
    phase_e             w_phase;

    always_comb begin
        if (r_state == S_IDLE)
            w_phase = PH_IDLE;
        else if ((r_state >= S_LOAD0) && (r_state <= S_LOAD3))
            w_phase = PH_LOAD;
        else if ((r_state >= S_CALC_FIRST) && (r_state <= S_CALC_LAST))
            w_phase = PH_CALC;
        else if (r_state == S_OUT)
            w_phase = PH_OUT;
        else
            w_phase = PH_BAD;
    end

    // Abort wins over everything; in IDLE it also suppresses a coincident Start.
    always_comb begin
        w_next   = r_state;
        w_finish = 1'b0;
        if (Abort) begin
            w_next = S_IDLE;
        end else begin
            case (w_phase)
                PH_IDLE: if (Start) w_next = S_LOAD0;
                PH_LOAD: if (Data_valid) w_next = r_state + STATE_W'(1);
                PH_CALC: w_next = r_state + STATE_W'(1);
                PH_OUT: begin
                    if (Out_ack) begin
                        w_next   = S_IDLE;
                        w_finish = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Flags are registered from the next state so they change only on the clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_done       <= w_finish;
            r_busy       <= (w_next != S_IDLE);
            r_data_ready <= (w_next >= S_LOAD0) && (w_next <= S_LOAD3);
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_run_count (
        .clk   (Clk),
        .rst   (Rst),
        .inc   (w_finish),
        .count (Run_count)
    );

    assign State      = r_state;
    assign Done       = r_done;
    assign Busy       = r_busy;
    assign Data_ready = r_data_ready;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed run scenarios plus random traffic against a phase/progress model.
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, dv, ack, abort;
    logic [3:0] state, state2;
    logic       dr, busy, done, dr2, busy2, done2;
    logic [7:0] rc;
    logic [1:0] rc2;

    op_sequencer #(.STATE_W(4), .CNT_W(8)) u_dut (
        .Clk(clk), .Rst(rst), .Start(start), .Data_valid(dv), .Out_ack(ack), .Abort(abort),
        .State(state), .Data_ready(dr), .Busy(busy), .Done(done), .Run_count(rc)
    );

    op_sequencer #(.STATE_W(4), .CNT_W(2)) u_dut_w2 (
        .Clk(clk), .Rst(rst), .Start(start), .Data_valid(dv), .Out_ack(ack), .Abort(abort),
        .State(state2), .Data_ready(dr2), .Busy(busy2), .Done(done2), .Run_count(rc2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: a run is a phase plus progress counts within that phase.
    localparam int M_IDLE = 0, M_LOAD = 1, M_CALC = 2, M_OUT = 3;
    int m_phase, m_loads, m_calc, m_runs;
    bit m_done;

    task automatic model_reset();
        m_phase = M_IDLE; m_loads = 0; m_calc = 0; m_runs = 0; m_done = 0;
    endtask

    task automatic model_step(input bit s, input bit d, input bit a, input bit ab);
        m_done = 0;
        if (ab) begin
            m_phase = M_IDLE;
        end else begin
            case (m_phase)
                M_IDLE: if (s) begin m_phase = M_LOAD; m_loads = 0; end
                M_LOAD: if (d) begin
                    if (m_loads == 3) begin m_phase = M_CALC; m_calc = 0; end
                    else m_loads++;
                end
                M_CALC: if (m_calc == 6) m_phase = M_OUT; else m_calc++;
                default: if (a) begin m_phase = M_IDLE; m_done = 1; m_runs++; end
            endcase
        end
    endtask

    function automatic int exp_state();
        case (m_phase)
            M_LOAD:  return 1 + m_loads;
            M_CALC:  return 5 + m_calc;
            M_OUT:   return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic compare_all();
        chk("state",        state,  exp_state());
        chk("busy",         busy,   int'(m_phase != M_IDLE));
        chk("data_ready",   dr,     int'(m_phase == M_LOAD));
        chk("done",         done,   int'(m_done));
        chk("run_count",    rc,     sat(m_runs, 255));
        chk("state_w2",     state2, exp_state());
        chk("busy_w2",      busy2,  int'(m_phase != M_IDLE));
        chk("data_ready_w2", dr2,   int'(m_phase == M_LOAD));
        chk("done_w2",      done2,  int'(m_done));
        chk("run_count_w2", rc2,    sat(m_runs, 3));
    endtask

    // Called at a falling edge: drive, let the rising edge act, then compare at the next falling edge.
    task automatic cycle(input bit s, input bit d, input bit a, input bit ab);
        start = s; dv = d; ack = a; abort = ab;
        @(posedge clk);
        model_step(s, d, a, ab);
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge; reset rises and falls between clock edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_state",      state, 0);
        chk("rst_run_count",  rc,    0);
        chk("rst_done",       done,  0);
        chk("rst_busy",       busy,  0);
        chk("rst_data_ready", dr,    0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    // One run from IDLE; done_at is the cycle (Start cycle = 1) in which Done is seen, 0 if none.
    task automatic run_once(input int stall_len, input int ack_wait, input int abort_at,
                            output int done_at, output int n_st2, output int n_st12);
        int stalled = 0;
        int waited  = 0;
        done_at = 0; n_st2 = 0; n_st12 = 0;
        cycle(1, 1, 1, 0);
        for (int i = 2; i < 60; i++) begin
            bit d, a, ab;
            if (done) begin done_at = i; break; end
            if (!busy) break;
            if (state == 2) n_st2++;
            if (state == 12) n_st12++;
            d = !((state == 2) && (stalled < stall_len));
            if (!d) stalled++;
            a = !((state == 12) && (waited < ack_wait));
            if (!a) waited++;
            ab = (state == abort_at);
            cycle(0, d, a, ab);
        end
    endtask

    initial begin
        int d_at, n2, n12;
        rst = 1'b1; start = 0; dv = 0; ack = 0; abort = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        run_once(0, 0, -1, d_at, n2, n12);
        chk("lat_basic", d_at, 14);
        chk("runs_1", rc, 1);

        run_once(3, 0, -1, d_at, n2, n12);
        chk("lat_stall", d_at, 17);
        chk("stall_state2_cycles", n2, 4);
        chk("rc_w2_run2", rc2, 2);

        run_once(0, 5, -1, d_at, n2, n12);
        chk("lat_ack_wait", d_at, 19);
        chk("out_cycles", n12, 6);
        chk("rc_w2_run3", rc2, 3);

        run_once(0, 0, 8, d_at, n2, n12);
        chk("abort_no_done", d_at, 0);
        chk("abort_state", state, 0);
        chk("abort_run_count", rc, 3);

        run_once(0, 0, -1, d_at, n2, n12);
        chk("run4_count", rc, 4);
        chk("rc_w2_saturated", rc2, 3);

        cycle(1, 1, 1, 0);
        for (int k = 0; k < 20 && state != 6; k++) cycle(0, 1, 1, 0);
        chk("reach_state6", state, 6);
        async_reset();
        cycle(0, 1, 1, 0);
        chk("idle_after_reset", state, 0);

        run_once(0, 0, -1, d_at, n2, n12);
        chk("lat_after_reset", d_at, 14);
        cycle(1, 1, 1, 0);
        chk("b2b_state", state, 1);
        chk("b2b_done_low", done, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
